mem_access_unit: RTL

- MEM stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register.
- Takes control bits and operands from EX/MEM. Performs loads and stores against an external data memory over a req/ack handshake.
- Drives mwreg_o, mm2reg_o, mrd_o, mr and mdata into the MEM/WB register.
- Raises mstall to freeze upstream stages until the memory access completes.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_timeout_ctr.sv | 27 ++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds FSM state encodings, the timeout fill pattern and default sizing.
// Imported by mem_access_unit and mem_timeout_ctr.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] MEM_TIMEOUT_DATA = 32'hDEADBEEF;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles without an ack; flags expiry at TIMEOUT-1.
// Latency: expire is combinational from the registered count.
// Backpressure: none; clear has priority over increment.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] r_cnt;

  // Cycle counter: cleared when a new access starts, stepped on each unacked BUSY cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_inc)   r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues one load/store per memory instruction over dmem req/ack.
// Latency: 1 cycle for non-memory ops, >= 3 cycles (IDLE, BUSY.., DONE) for loads/stores.
// Backpressure: mstall freezes upstream while an access is pending; optional
// BUSY timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic              mwmem,
  input  logic [4:0]        mrd,
  input  logic [31:0]       malu,
  input  logic [31:0]       mb,
  output logic              mwreg_o,
  output logic              mm2reg_o,
  output logic [4:0]        mrd_o,
  output logic [31:0]       mr,
  output logic [31:0]       mdata,
  output logic              mstall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              merr
);

  state_t              r_state;
  state_t              w_next;
  logic                w_access;
  logic                w_start;
  logic                w_ack_hit;
  logic                w_timeout;
  logic                w_stall;
  logic                w_req;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_we;
  logic [31:0]         r_rdata;

  assign w_access  = mm2reg | mwmem;
  assign w_start   = (r_state == IDLE) && w_access;
  // Acks arriving outside BUSY are meaningless and dropped here
  assign w_ack_hit = (r_state == BUSY) && dmem_ack;

`ifdef MEM_TIMEOUT_EN
  logic w_expire;
  logic r_merr;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_start),
    .i_inc    ((r_state == BUSY) && !dmem_ack),
    .o_expire (w_expire)
  );

  // An ack on the limit cycle is a normal completion, so timeout requires no ack
  assign w_timeout = (r_state == BUSY) && !dmem_ack && w_expire;

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_merr <= 1'b0;
    else if (w_timeout) r_merr <= 1'b1;
  end

  assign merr = r_merr;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout = 1'b0;
  assign merr      = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: DONE always returns to IDLE because EX/MEM advances after it
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_access) w_next = BUSY;
      BUSY:    if (w_ack_hit || w_timeout) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs per state: stall while an access is starting or in flight
  always_comb begin
    w_stall = 1'b0;
    w_req   = 1'b0;
    case (r_state)
      IDLE: w_stall = w_access;
      BUSY: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
      end
      default: ;
    endcase
  end

  // Request operands latched at access start and held stable through BUSY
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_start) begin
      r_addr  <= malu[ADDR_W+1:2];
      r_wdata <= mb;
      r_we    <= mwmem;
    end
  end

  // Load data capture; a timed-out load returns the poison pattern instead
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  r_rdata <= '0;
    else if (w_ack_hit && !r_we) r_rdata <= dmem_rdata;
    else if (w_timeout)          r_rdata <= MEM_TIMEOUT_DATA;
  end

  // Stall inserts a bubble by masking the write-enables only
  assign mstall     = w_stall;
  assign dmem_req   = w_req;
  assign mwreg_o    = mwreg & ~w_stall;
  assign mm2reg_o   = mm2reg & ~w_stall;
  assign mrd_o      = mrd;
  assign mr         = malu;
  assign mdata      = r_rdata;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;

endmodule
